hilo_muldiv_ctrl: RTL

Multi-cycle sequencer for the HI/LO resource of the five-stage MIPS pipeline. Sits beside EX: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs an iterative divider (and optionally multiplier). Raises a stall request to the stall controller while busy, then presents the 66-bit HI/LO write bundle that travels EX→MEM→WB.

---
 rtl/hilo_muldiv_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multi-cycle sequencer: restoring divider, single-cycle or iterative multiplier.
// Define MULDIV_ITER_MUL_EN to route MULT/MULTU through the 32-step shift-add path.
module hilo_muldiv_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        ex_stall,
   input  logic        issue_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        stallreq,
   output logic [65:0] hilo_bus,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [32:0] acc_q, acc_d;     // partial remainder (div) / product high + carry (mul)
   logic [31:0] sh_q, sh_d;       // dividend->quotient (div) / multiplier->product low (mul)
   logic [31:0] opb_q, opb_d;     // divisor (div) / multiplicand (mul)
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
`ifdef MULDIV_ITER_MUL_EN
   logic        is_div_q, is_div_d;
   logic [32:0] mul_sum;
`else
   logic [63:0] prod_abs;
`endif

   logic        is_signed;
   logic        start;
   logic [31:0] abs_a, abs_b;
   logic [33:0] rem_sh, diff;
   logic [32:0] step_acc;
   logic [31:0] step_sh;
   logic [63:0] prod_fix;

   always_comb begin
      is_signed = ~op[0];
      abs_a     = (is_signed && src_a[31]) ? -src_a : src_a;
      abs_b     = (is_signed && src_b[31]) ? -src_b : src_b;
      start     = (state_q == S_IDLE) && issue_valid && !op[2] && !flush;

      // Borrow out of the 34-bit subtract doubles as the "rem < divisor" compare.
      rem_sh    = {acc_q, sh_q[31]};
      diff      = rem_sh - {2'b00, opb_q};
      step_acc  = diff[33] ? rem_sh[32:0] : diff[32:0];
      step_sh   = {sh_q[30:0], ~diff[33]};
`ifdef MULDIV_ITER_MUL_EN
      mul_sum   = acc_q + {1'b0, (sh_q[0] ? opb_q : 32'h0)};
      if (!is_div_q) begin
         step_acc = {1'b0, mul_sum[32:1]};
         step_sh  = {mul_sum[0], sh_q[31:1]};
      end
      prod_fix  = qneg_q ? -{step_acc[31:0], step_sh} : {step_acc[31:0], step_sh};
`else
      prod_abs  = {32'h0, abs_a} * {32'h0, abs_b};
      prod_fix  = (is_signed && (src_a[31] ^ src_b[31])) ? -prod_abs : prod_abs;
`endif
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      sh_d     = sh_q;
      opb_d    = opb_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
`ifdef MULDIV_ITER_MUL_EN
      is_div_d = is_div_q;
`endif
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  cnt_d  = '0;
                  qneg_d = is_signed & (src_a[31] ^ src_b[31]);
                  rneg_d = is_signed & src_a[31];
`ifdef MULDIV_ITER_MUL_EN
                  is_div_d = op[1];
`endif
                  if (op[1]) begin
                     if (src_b == '0) begin
                        hi_d    = src_a;
                        lo_d    = '1;
                        state_d = S_DONE;
                     end else begin
                        acc_d   = '0;
                        sh_d    = abs_a;
                        opb_d   = abs_b;
                        state_d = S_RUN;
                     end
                  end else begin
`ifdef MULDIV_ITER_MUL_EN
                     acc_d   = '0;
                     sh_d    = abs_b;
                     opb_d   = abs_a;
                     state_d = S_RUN;
`else
                     {hi_d, lo_d} = prod_fix;
                     state_d      = S_DONE;
`endif
                  end
               end
            end
            S_RUN: begin
               acc_d = step_acc;
               sh_d  = step_sh;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_d = S_DONE;
                  hi_d    = rneg_q ? -step_acc[31:0] : step_acc[31:0];
                  lo_d    = qneg_q ? -step_sh : step_sh;
`ifdef MULDIV_ITER_MUL_EN
                  if (!is_div_q) {hi_d, lo_d} = prod_fix;
`endif
               end
            end
            S_DONE: begin
               if (!ex_stall) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         sh_q     <= '0;
         opb_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef MULDIV_ITER_MUL_EN
         is_div_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         sh_q     <= sh_d;
         opb_q    <= opb_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef MULDIV_ITER_MUL_EN
         is_div_q <= is_div_d;
`endif
      end
   end

   always_comb begin
      hilo_bus = '0;
      if (!rst && !flush) begin
         if (state_q == S_DONE) begin
            hilo_bus = {2'b11, hi_q, lo_q};
         end else if (state_q == S_IDLE && issue_valid) begin
            if (op == 3'd4) hilo_bus = {2'b10, src_a, 32'h0};
            else if (op == 3'd5) hilo_bus = {2'b01, 32'h0, src_a};
         end
      end
      stallreq = start || (state_q == S_RUN);
      busy     = (state_q != S_IDLE);
   end

endmodule
